// File: rtl/smart_array_controller_if.sv
// Job request and array-control bundle for the systolic tile sequencer.
// The master side issues jobs; the slave side is the controller.
interface smart_array_controller_if #(
    parameter int K_WIDTH     = 8,
    parameter int NUM_HOR_SSR = 2,
    parameter int NUM_VER_SSR = 2
);
    logic                   start_in;
    logic                   mode_in;
    logic [K_WIDTH-1:0]     k_len_in;
    logic [NUM_HOR_SSR-1:0] hor_ssr_cfg_in;
    logic [NUM_VER_SSR-1:0] ver_ssr_cfg_in;
    logic                   busy_out;
    logic                   done_out;
    logic                   fsm_op2_select_out;
    logic                   fsm_out_select_out;
    logic                   stat_bit_out;
    logic [NUM_HOR_SSR-1:0] hor_ssr_bits_out;
    logic [NUM_VER_SSR-1:0] ver_ssr_bits_out;
    logic                   feed_valid_out;
    logic                   feed_sel_out;
    logic [K_WIDTH-1:0]     feed_idx_out;
    logic                   drain_valid_out;

    modport master (
        output start_in, mode_in, k_len_in, hor_ssr_cfg_in, ver_ssr_cfg_in,
        input  busy_out, done_out, fsm_op2_select_out, fsm_out_select_out,
        input  stat_bit_out, hor_ssr_bits_out, ver_ssr_bits_out,
        input  feed_valid_out, feed_sel_out, feed_idx_out, drain_valid_out
    );

    modport slave (
        input  start_in, mode_in, k_len_in, hor_ssr_cfg_in, ver_ssr_cfg_in,
        output busy_out, done_out, fsm_op2_select_out, fsm_out_select_out,
        output stat_bit_out, hor_ssr_bits_out, ver_ssr_bits_out,
        output feed_valid_out, feed_sel_out, feed_idx_out, drain_valid_out
    );
endinterface

// File: rtl/smart_array_controller.sv
// Tile-level sequencer for a systolic array of smart MAC PEs.
// Moore FSM: every output decodes from the registered state and phase counter.
module smart_array_controller #(
    parameter int ARRAY_ROWS  = 4,
    parameter int ARRAY_COLS  = 4,
    parameter int K_WIDTH     = 8,
    parameter int NUM_HOR_SSR = 2,
    parameter int NUM_VER_SSR = 2
) (
    input logic                  clk,
    input logic                  rst,
    smart_array_controller_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_STREAM, S_FLUSH, S_DRAIN, S_DONE
    } state_t;

    localparam logic [K_WIDTH-1:0] CLEAR_LAST = K_WIDTH'(ARRAY_ROWS + ARRAY_COLS - 1);
    localparam logic [K_WIDTH-1:0] FLUSH_LAST = K_WIDTH'(ARRAY_ROWS + ARRAY_COLS - 2);
    localparam logic [K_WIDTH-1:0] ROWS_LAST  = K_WIDTH'(ARRAY_ROWS - 1);

    state_t                 state_q, state_d;
    logic [K_WIDTH-1:0]     cnt_q;
    logic                   ws_q;
    logic [K_WIDTH-1:0]     k_q;
    logic [NUM_HOR_SSR-1:0] hor_q;
    logic [NUM_VER_SSR-1:0] ver_q;
    logic                   ws_tail;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Phase counter restarts on each state entry; job config captured at accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            ws_q  <= 1'b0;
            k_q   <= '0;
            hor_q <= '0;
            ver_q <= '0;
        end else begin
            if (state_d != state_q)
                cnt_q <= '0;
            else if (state_q != S_IDLE)
                cnt_q <= cnt_q + 1'b1;
            if (state_q == S_IDLE && bus.start_in) begin
                ws_q  <= bus.mode_in;
                k_q   <= bus.k_len_in;
                hor_q <= bus.hor_ssr_cfg_in;
                ver_q <= bus.ver_ssr_cfg_in;
            end
        end
    end

    // Phase sequencing; an empty job skips the stream phase entirely
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:
                if (bus.start_in)
                    state_d = bus.mode_in ? S_LOAD : S_CLEAR;
            S_CLEAR:
                if (cnt_q == CLEAR_LAST)
                    state_d = (k_q == '0) ? S_FLUSH : S_STREAM;
            S_LOAD:
                if (cnt_q == ROWS_LAST)
                    state_d = (k_q == '0) ? S_FLUSH : S_STREAM;
            S_STREAM:
                if (cnt_q == k_q - 1'b1)
                    state_d = S_FLUSH;
            S_FLUSH:
                if (cnt_q == FLUSH_LAST)
                    state_d = ws_q ? S_DONE : S_DRAIN;
            S_DRAIN:
                if (cnt_q == ROWS_LAST)
                    state_d = S_DONE;
            S_DONE:
                state_d = S_IDLE;
            default:
                state_d = S_IDLE;
        endcase
    end

    assign ws_tail = ws_q && (state_q == S_STREAM || state_q == S_FLUSH);

    // Array-wide control decode
    always_comb begin
        bus.busy_out           = (state_q != S_IDLE);
        bus.done_out           = (state_q == S_DONE);
        bus.fsm_op2_select_out = (state_q == S_LOAD) && (cnt_q == ROWS_LAST);
        bus.fsm_out_select_out = (state_q == S_DRAIN) || ws_tail;
        bus.stat_bit_out       = (state_q == S_CLEAR) || (state_q == S_LOAD) || ws_tail;
        bus.feed_valid_out     = (state_q == S_LOAD) || (state_q == S_STREAM);
        bus.feed_sel_out       = (state_q == S_LOAD);
        bus.drain_valid_out    = (state_q == S_DRAIN) || ws_tail;
        bus.feed_idx_out       = '0;
        bus.hor_ssr_bits_out   = '0;
        bus.ver_ssr_bits_out   = '0;
        if (state_q == S_LOAD || state_q == S_STREAM || state_q == S_DRAIN)
            bus.feed_idx_out = cnt_q;
        if (state_q != S_IDLE) begin
            bus.hor_ssr_bits_out = hor_q;
            bus.ver_ssr_bits_out = ver_q;
        end
    end
endmodule

// File: tb/tb_smart_array_controller.sv
// Directed bench for smart_array_controller (4x4 array, 8-bit counters).
// Cycle 0 is the cycle in which start_in is sampled high.
module tb_smart_array_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run  = 0;
    int   n_fail = 0;

    smart_array_controller_if #(.K_WIDTH(8), .NUM_HOR_SSR(2), .NUM_VER_SSR(2)) bus ();

    smart_array_controller #(
        .ARRAY_ROWS(4), .ARRAY_COLS(4), .K_WIDTH(8),
        .NUM_HOR_SSR(2), .NUM_VER_SSR(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    // {busy, done, op2, out_sel, stat, feed_valid, feed_sel, drain_valid}
    function automatic logic [7:0] ctl();
        return {bus.busy_out, bus.done_out, bus.fsm_op2_select_out,
                bus.fsm_out_select_out, bus.stat_bit_out, bus.feed_valid_out,
                bus.feed_sel_out, bus.drain_valid_out};
    endfunction

    task automatic issue(input logic mode, input logic [7:0] k);
        @(negedge clk);
        bus.mode_in  = mode;
        bus.k_len_in = k;
        bus.start_in = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start_in = 1'b0;
        bus.mode_in = 1'b0;
        bus.k_len_in = '0;
        bus.hor_ssr_cfg_in = 2'b11;
        bus.ver_ssr_cfg_in = 2'b11;
        repeat (2) @(negedge clk);
        n_run++;
        if (ctl() !== 8'h00 || bus.feed_idx_out !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_ctl got %b/%0d want 00000000/0", ctl(), bus.feed_idx_out);
        end
        n_run++;
        if (bus.hor_ssr_bits_out !== 2'b00 || bus.ver_ssr_bits_out !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ssr got %b %b want 00 00", bus.hor_ssr_bits_out, bus.ver_ssr_bits_out);
        end
        bus.hor_ssr_cfg_in = 2'b00;
        bus.ver_ssr_cfg_in = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_os();
        logic [7:0] e;
        int ei;
        issue(1'b0, 8'd8);
        for (int c = 1; c <= 29; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            e = {c <= 28, c == 28, 1'b0, c >= 24 && c <= 27, c <= 8,
                 c >= 9 && c <= 16, 1'b0, c >= 24 && c <= 27};
            ei = (c >= 9 && c <= 16) ? c - 9 : (c >= 24 && c <= 27) ? c - 24 : 0;
            n_run++;
            if (ctl() !== e || bus.feed_idx_out !== 8'(ei)) begin
                n_fail++;
                $display("FAIL os_k8 cyc %0d got %b/%0d want %b/%0d", c, ctl(), bus.feed_idx_out, e, ei);
            end
        end
    endtask

    task automatic test_ws();
        logic [7:0] e;
        int ei;
        issue(1'b1, 8'd8);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            e = {c <= 20, c == 20, c == 4, c >= 5 && c <= 19, c <= 19,
                 c <= 12, c <= 4, c >= 5 && c <= 19};
            ei = (c <= 4) ? c - 1 : (c <= 12) ? c - 5 : 0;
            n_run++;
            if (ctl() !== e || bus.feed_idx_out !== 8'(ei)) begin
                n_fail++;
                $display("FAIL ws_k8 cyc %0d got %b/%0d want %b/%0d", c, ctl(), bus.feed_idx_out, e, ei);
            end
        end
    endtask

    task automatic test_k_zero();
        logic [7:0] e;
        int ei;
        issue(1'b0, 8'd0);
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            e = {c <= 20, c == 20, 1'b0, c >= 16 && c <= 19, c <= 8,
                 1'b0, 1'b0, c >= 16 && c <= 19};
            ei = (c >= 16 && c <= 19) ? c - 16 : 0;
            n_run++;
            if (ctl() !== e || bus.feed_idx_out !== 8'(ei)) begin
                n_fail++;
                $display("FAIL os_k0 cyc %0d got %b/%0d want %b/%0d", c, ctl(), bus.feed_idx_out, e, ei);
            end
        end
        issue(1'b1, 8'd0);
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            bus.start_in = 1'b0;
            e = {c <= 12, c == 12, c == 4, c >= 5 && c <= 11, c <= 11,
                 c <= 4, c <= 4, c >= 5 && c <= 11};
            ei = (c <= 4) ? c - 1 : 0;
            n_run++;
            if (ctl() !== e || bus.feed_idx_out !== 8'(ei)) begin
                n_fail++;
                $display("FAIL ws_k0 cyc %0d got %b/%0d want %b/%0d", c, ctl(), bus.feed_idx_out, e, ei);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic eb, ed;
        issue(1'b0, 8'd2);
        for (int c = 1; c <= 47; c++) begin
            @(negedge clk);
            if (c == 30) bus.start_in = 1'b0;
            eb = (c <= 22) || (c >= 24 && c <= 45);
            ed = (c == 22) || (c == 45);
            n_run++;
            if (bus.busy_out !== eb || bus.done_out !== ed) begin
                n_fail++;
                $display("FAIL b2b cyc %0d got busy %b done %b want %b %b", c, bus.busy_out, bus.done_out, eb, ed);
            end
        end
        bus.start_in = 1'b0;
    endtask

    task automatic test_config();
        logic [1:0] eh, ev;
        bus.hor_ssr_cfg_in = 2'b10;
        bus.ver_ssr_cfg_in = 2'b01;
        issue(1'b0, 8'd1);
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            bus.start_in = (c == 5);
            if (c == 1) begin
                bus.hor_ssr_cfg_in = 2'b01;
                bus.ver_ssr_cfg_in = 2'b10;
                bus.mode_in = 1'b1;
                bus.k_len_in = 8'd50;
            end
            eh = (c <= 21) ? 2'b10 : 2'b00;
            ev = (c <= 21) ? 2'b01 : 2'b00;
            n_run++;
            if (bus.hor_ssr_bits_out !== eh || bus.ver_ssr_bits_out !== ev ||
                bus.busy_out !== (c <= 21) || bus.done_out !== (c == 21)) begin
                n_fail++;
                $display("FAIL cfg cyc %0d got %b %b busy %b done %b want %b %b %b %b", c,
                         bus.hor_ssr_bits_out, bus.ver_ssr_bits_out, bus.busy_out, bus.done_out,
                         eh, ev, c <= 21, c == 21);
            end
        end
        bus.start_in = 1'b0;
        bus.hor_ssr_cfg_in = 2'b00;
        bus.ver_ssr_cfg_in = 2'b00;
    endtask

    task automatic test_reset_mid_job();
        bus.hor_ssr_cfg_in = 2'b11;
        issue(1'b1, 8'd8);
        @(negedge clk);
        bus.start_in = 1'b0;
        bus.hor_ssr_cfg_in = 2'b00;
        repeat (5) @(negedge clk);
        n_run++;
        if (bus.drain_valid_out !== 1'b1 || bus.feed_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_pre got dv %b fv %b want 1 1", bus.drain_valid_out, bus.feed_valid_out);
        end
        rst = 1'b1;
        #1;
        n_run++;
        if (ctl() !== 8'h00 || bus.hor_ssr_bits_out !== 2'b00 || bus.feed_idx_out !== 8'd0) begin
            n_fail++;
            $display("FAIL midrst_now got %b/%b/%0d want 00000000/00/0", ctl(), bus.hor_ssr_bits_out, bus.feed_idx_out);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_run++;
            if (bus.done_out !== 1'b0 || bus.busy_out !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_hold got busy %b done %b want 0 0", bus.busy_out, bus.done_out);
            end
        end
        rst = 1'b0;
        issue(1'b0, 8'd8);
        @(negedge clk);
        bus.start_in = 1'b0;
        n_run++;
        if (bus.busy_out !== 1'b1 || bus.stat_bit_out !== 1'b1 || bus.feed_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_restart got busy %b stat %b fv %b want 1 1 0", bus.busy_out, bus.stat_bit_out, bus.feed_valid_out);
        end
        repeat (27) @(negedge clk);
        n_run++;
        if (bus.done_out !== 1'b1) begin
            n_fail++;
            $display("FAIL midrst_done got %b want 1", bus.done_out);
        end
        @(negedge clk);
        n_run++;
        if (bus.busy_out !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle got busy %b want 0", bus.busy_out);
        end
    endtask

    initial begin
        test_reset();
        test_os();
        test_ws();
        test_k_zero();
        test_back_to_back();
        test_config();
        test_reset_mid_job();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/smart_array_controller.md
Name: smart_array_controller

Overview:
- Tile-level sequencer for an ARRAY_ROWS x ARRAY_COLS systolic array of smart MAC PEs.
- Accepts one job per start pulse and drives the array-wide controls: fsm_op2_select, fsm_out_select, stat_bit, and horizontal/vertical SSR bypass bits.
- Tells the edge operand feeders and result collectors when to push or pop.
- Supports output-stationary (OS) and weight-stationary (WS) dataflows.

Parameters:
- ARRAY_ROWS, 4, PE rows.
- ARRAY_COLS, 4, PE columns.
- K_WIDTH, 8, width of the job length and phase counters. Requires ARRAY_ROWS+ARRAY_COLS < 2**K_WIDTH.
- NUM_HOR_SSR, 2, width of the horizontal SSR bit bus.
- NUM_VER_SSR, 2, width of the vertical SSR bit bus.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start_in  input  1  job request; sampled only in IDLE.
- mode_in  input  1  0 = OS, 1 = WS; captured with start.
- k_len_in  input  K_WIDTH  number of streamed operand vectors; captured with start.
- hor_ssr_cfg_in  input  NUM_HOR_SSR  horizontal bypass pattern; captured with start.
- ver_ssr_cfg_in  input  NUM_VER_SSR  vertical bypass pattern; captured with start.
- busy_out  output  1  high whenever the state is not IDLE.
- done_out  output  1  one-cycle completion pulse.
- fsm_op2_select_out  output  1  stationary-register load strobe to all PEs.
- fsm_out_select_out  output  1  bottom output select to all PEs (1 = accumulator).
- stat_bit_out  output  1  PE operand mux select.
- hor_ssr_bits_out  output  NUM_HOR_SSR  drives the leftmost column's hor_ssr_bits_in.
- ver_ssr_bits_out  output  NUM_VER_SSR  drives the top row's ver_ssr_bits_in.
- feed_valid_out  output  1  feeders present one vector this cycle. When low, feeders drive zero (system contract).
- feed_sel_out  output  1  0 = activation stream, 1 = weight load.
- feed_idx_out  output  K_WIDTH  index of the vector within the current phase, starting at 0.
- drain_valid_out  output  1  collectors sample the bottom-row outputs this cycle.

Behaviour:
- Moore FSM. All outputs decode from the registered state and phase counter; there is no combinational path from inputs to outputs.
- Reset (asynchronous): state IDLE, counter 0, captured config 0, all outputs 0.
- Reset mid-job: same result immediately; the job is abandoned and no done pulse is produced.
- Job acceptance:
  - In IDLE, start_in=1 captures mode, k_len and SSR config.
  - Next state is CLEAR (OS) or LOAD (WS).
  - start_in while busy is ignored and does not queue.
- OS sequence:
  - CLEAR: ARRAY_ROWS+ARRAY_COLS cycles. stat_bit=1, out_sel=0, feed_valid=0. Zero operands reach every PE, so every accumulator is cleared.
  - STREAM: k_len cycles. stat_bit=0, out_sel=0, feed_valid=1, feed_sel=0, feed_idx 0..k_len-1.
  - FLUSH: ARRAY_ROWS+ARRAY_COLS-1 cycles. stat_bit=0, feed_valid=0; skewed operands drain through the array.
  - DRAIN: ARRAY_ROWS cycles. out_sel=1, drain_valid=1, feed_idx counts 0..ARRAY_ROWS-1.
  - DONE: then IDLE.
- WS sequence:
  - LOAD: ARRAY_ROWS cycles. stat_bit=1, out_sel=0, feed_valid=1, feed_sel=1, feed_idx 0..ARRAY_ROWS-1.
  - fsm_op2_select_out=1 only on the last LOAD cycle, so every row captures its weight simultaneously.
  - STREAM: k_len cycles. stat_bit=1, out_sel=1, feed_valid=1, feed_sel=0, drain_valid=1.
  - FLUSH: ARRAY_ROWS+ARRAY_COLS-1 cycles. stat_bit=1, out_sel=1, feed_valid=0, drain_valid=1.
  - DONE: then IDLE.
- DONE state: one cycle with done_out=1 and busy_out=1; all other controls are 0.
- k_len=0: STREAM is skipped (CLEAR/LOAD goes directly to FLUSH). feed_valid is never 1 with feed_sel=0.
- SSR bits: hor_ssr_bits_out and ver_ssr_bits_out equal the captured config in every non-IDLE state, and 0 in IDLE.
- fsm_op2_select_out is 0 in every OS state.
- Counter: reloads to 0 on every state entry and never wraps within a phase.

Test Plan:
- Reset mid-job: assert rst during WS STREAM -> outputs 0 in the same cycle, no done pulse, and a new start accepted after rst is released.
- OS, ROWS=COLS=4, k_len=8, start at cycle 0 -> CLEAR cycles 1-8, feed_valid cycles 9-16 with idx 0..7, drain_valid cycles 24-27, done_out high at cycle 28 only.
- WS, ROWS=COLS=4, k_len=8, start at cycle 0 -> feed_sel=1 cycles 1-4, op2_select only at cycle 4, drain_valid and out_sel cycles 5-19, done at cycle 20.
- k_len=0 in both modes -> no feed_sel=0 beats; OS done at cycle 20, WS done at cycle 12.
- start_in held high through a full job -> exactly two jobs run back to back: second accepted in the IDLE cycle after done; busy_out low for exactly that one cycle.
- Config capture: hor cfg 2'b10, ver cfg 2'b01, then change inputs mid-job -> outputs hold 2'b10 and 2'b01 until done, then return to 0 in IDLE.
